// File: rtl/cpu_phase_monitor_pkg.sv
// ---------------------------------------------------------------------------
// cpu_phase_pkg
//   Shared definitions for the CPU phase-sequence monitor and for any trace
//   logic that decodes the same 15-strobe phase bus.
//
//   Contents:
//     NUM_PHASES          strobes per CPU cycle (width of the strobe bus)
//     STROBE_GAP_DEFAULT  default clk distance between consecutive strobes
//     GAP_W_DEFAULT       default gap-counter width (must hold STROBE_GAP+1)
//     PH_1 .. PH_12       phase index of each strobe, in bus bit order
//     phase_state_e       monitor FSM states
//     next_phase()        successor of a phase index, wrapping PH_12 -> PH_1
// ---------------------------------------------------------------------------
package cpu_phase_pkg;

    localparam int NUM_PHASES         = 15;
    localparam int STROBE_GAP_DEFAULT = 2;
    localparam int GAP_W_DEFAULT      = 4;

    // Phase indices; the value equals the strobe bit position on the bus.
    localparam logic [3:0] PH_1   = 4'd0;
    localparam logic [3:0] PH_2   = 4'd1;
    localparam logic [3:0] PH_3   = 4'd2;
    localparam logic [3:0] PH_4   = 4'd3;
    localparam logic [3:0] PH_4_2 = 4'd4;
    localparam logic [3:0] PH_5   = 4'd5;
    localparam logic [3:0] PH_6   = 4'd6;
    localparam logic [3:0] PH_6_2 = 4'd7;
    localparam logic [3:0] PH_7   = 4'd8;
    localparam logic [3:0] PH_8   = 4'd9;
    localparam logic [3:0] PH_8_2 = 4'd10;
    localparam logic [3:0] PH_9   = 4'd11;
    localparam logic [3:0] PH_10  = 4'd12;
    localparam logic [3:0] PH_11  = 4'd13;
    localparam logic [3:0] PH_12  = 4'd14;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } phase_state_e;

    function automatic logic [3:0] next_phase(input logic [3:0] idx);
        return (idx == PH_12) ? PH_1 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/cpu_phase_monitor_if.sv
// ---------------------------------------------------------------------------
// cpu_phase_monitor_if
//   Bundles the phase strobe bus, the error-clear pulse and all monitor
//   results.
//
//   master : the environment (phase generator side + debug/fault consumers);
//            drives strobe_in and clear_err, observes the results.
//   slave  : the monitor; receives strobe_in/clear_err, drives
//            phase_valid, phase_idx, cycle_start, cycle_done, locked,
//            err_multi, err_order, err_gap, err_timeout, cycle_count.
// ---------------------------------------------------------------------------
interface cpu_phase_monitor_if;

    logic [cpu_phase_pkg::NUM_PHASES-1:0] strobe_in;
    logic                                 clear_err;
    logic                                 phase_valid;
    logic [3:0]                           phase_idx;
    logic                                 cycle_start;
    logic                                 cycle_done;
    logic                                 locked;
    logic                                 err_multi;
    logic                                 err_order;
    logic                                 err_gap;
    logic                                 err_timeout;
    logic [15:0]                          cycle_count;

    modport master (
        output strobe_in, clear_err,
        input  phase_valid, phase_idx, cycle_start, cycle_done, locked,
               err_multi, err_order, err_gap, err_timeout, cycle_count
    );

    modport slave (
        input  strobe_in, clear_err,
        output phase_valid, phase_idx, cycle_start, cycle_done, locked,
               err_multi, err_order, err_gap, err_timeout, cycle_count
    );

endinterface

// File: rtl/cpu_phase_onehot_dec.sv
// ---------------------------------------------------------------------------
// cpu_phase_onehot_dec
//   Combinational decode of the 15-bit phase strobe bus.
//
//   strobe  in   NUM_PHASES  strobe vector (bit0 = clock_1 ... bit14 = clock_12)
//   valid   out  1           exactly one strobe bit is set
//   multi   out  1           more than one strobe bit is set
//   idx     out  4           position of the set bit (meaningful when valid)
// ---------------------------------------------------------------------------
module cpu_phase_onehot_dec
    import cpu_phase_pkg::*;
(
    input  logic [NUM_PHASES-1:0] strobe,
    output logic                  valid,
    output logic                  multi,
    output logic [3:0]            idx
);

    logic [3:0] count;

    // NOTE: every output of a combinational block gets a default before any
    //       conditional assignment, so no path leaves it unassigned (latch).
    always_comb begin
        count = '0;
        idx   = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (strobe[i]) begin
                count = count + 4'd1;
                idx   = 4'(i);
            end
        end
        valid = (count == 4'd1);
        multi = (count > 4'd1);
    end

endmodule

// File: rtl/cpu_phase_monitor.sv
// ---------------------------------------------------------------------------
// cpu_phase_monitor
//   Receives the 15-strobe CPU phase sequence, locks onto it and reports the
//   current phase plus sticky protocol-violation flags.
//
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous, active-high reset
//     bus    slave modport of cpu_phase_monitor_if:
//              strobe_in  (in)  strobe bus, bit0 = clock_1 ... bit14 = clock_12
//              clear_err  (in)  pulse clearing the sticky error flags
//              phase_valid/phase_idx/cycle_start/cycle_done  accepted strobe
//              locked                 FSM is in LOCK
//              err_multi/err_order/err_gap/err_timeout   sticky errors
//              cycle_count            completed CPU cycles
//
//   Parameters:
//     STROBE_GAP  required clk distance between consecutive strobes
//     GAP_W       gap-counter width, must hold STROBE_GAP+1
//
//   Build option:
//     CPU_PHASE_MON_CYCCNT_EN  when defined, cycle_count counts cycle_done
//                              pulses (wrapping, reset-only clear); when
//                              undefined cycle_count is tied to zero.
//
//   Timing: strobe_in is registered once (s_q) and all outputs are
//   registered, so a strobe presented in cycle N is reported in cycle N+2.
// ---------------------------------------------------------------------------
module cpu_phase_monitor
    import cpu_phase_pkg::*;
#(
    parameter int STROBE_GAP = STROBE_GAP_DEFAULT,
    parameter int GAP_W      = GAP_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_phase_monitor_if.slave   bus
);

    localparam logic [0:0]       ST_HUNT = 1'(HUNT);
    localparam logic [0:0]       ST_LOCK = 1'(LOCK);
    localparam logic [GAP_W-1:0] GAP_MAX = '1;
    localparam logic [GAP_W:0]   GAP_REQ = (GAP_W+1)'(STROBE_GAP);

    logic [NUM_PHASES-1:0] s_q;
    logic [0:0]            state;
    logic [3:0]            expected;
    logic [GAP_W-1:0]      gap_cnt;

    logic                  dec_valid;
    logic                  dec_multi;
    logic [3:0]            dec_idx;

    logic                  phase_valid_q;
    logic [3:0]            phase_idx_q;
    logic                  cycle_start_q;
    logic                  cycle_done_q;
    logic                  err_multi_q;
    logic                  err_order_q;
    logic                  err_gap_q;
    logic                  err_timeout_q;

    cpu_phase_onehot_dec u_dec (
        .strobe (s_q),
        .valid  (dec_valid),
        .multi  (dec_multi),
        .idx    (dec_idx)
    );

    // One extra bit so counter+1 cannot wrap when the counter is saturated.
    logic [GAP_W:0] gap_plus1;
    logic           early;
    logic           late;

    assign gap_plus1 = {1'b0, gap_cnt} + (GAP_W+1)'(1);
    assign early     = (gap_plus1 < GAP_REQ);
    assign late      = (gap_plus1 > GAP_REQ);

    logic accept;
    logic ev_multi;
    logic ev_order;
    logic ev_gap;
    logic ev_timeout;
    logic drop_lock;

    always_comb begin
        accept     = 1'b0;
        ev_multi   = 1'b0;
        ev_order   = 1'b0;
        ev_gap     = 1'b0;
        ev_timeout = 1'b0;
        if (state == ST_HUNT) begin
            // Only clock_1 can start a lock; other single strobes are ignored.
            if (dec_multi) begin
                ev_multi = 1'b1;
            end else if (dec_valid && (dec_idx == PH_1)) begin
                accept = 1'b1;
            end
        end else begin
            if (dec_multi) begin
                ev_multi = 1'b1;
            end else if (dec_valid) begin
                if (early) begin
                    ev_gap = 1'b1;
                end else if (late) begin
                    // A strobe past the window missed its slot: same as no strobe.
                    ev_timeout = 1'b1;
                end else if (dec_idx != expected) begin
                    ev_order = 1'b1;
                end else begin
                    accept = 1'b1;
                end
            end else if (late) begin
                ev_timeout = 1'b1;
            end
        end
        drop_lock = (state == ST_LOCK) && (ev_multi || ev_gap || ev_order || ev_timeout);
    end

    // NOTE: state is updated with non-blocking assignments so every flop in
    //       this block samples the pre-edge values, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Clearing s_q here is what discards strobes seen during reset.
            s_q           <= '0;
            state         <= ST_HUNT;
            expected      <= PH_1;
            gap_cnt       <= '0;
            phase_valid_q <= 1'b0;
            phase_idx_q   <= PH_1;
            cycle_start_q <= 1'b0;
            cycle_done_q  <= 1'b0;
            err_multi_q   <= 1'b0;
            err_order_q   <= 1'b0;
            err_gap_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            s_q <= bus.strobe_in;

            if (accept) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_MAX) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end

            phase_valid_q <= accept;
            cycle_start_q <= accept && (dec_idx == PH_1);
            cycle_done_q  <= accept && (dec_idx == PH_12);

            if (accept) begin
                phase_idx_q <= dec_idx;
                expected    <= next_phase(dec_idx);
                state       <= ST_LOCK;
            end else if (drop_lock) begin
                expected    <= PH_1;
                state       <= ST_HUNT;
            end

            // A new event wins over a simultaneous clear.
            err_multi_q   <= (err_multi_q   && !bus.clear_err) || ev_multi;
            err_order_q   <= (err_order_q   && !bus.clear_err) || ev_order;
            err_gap_q     <= (err_gap_q     && !bus.clear_err) || ev_gap;
            err_timeout_q <= (err_timeout_q && !bus.clear_err) || ev_timeout;
        end
    end

    assign bus.phase_valid = phase_valid_q;
    assign bus.phase_idx   = phase_idx_q;
    assign bus.cycle_start = cycle_start_q;
    assign bus.cycle_done  = cycle_done_q;
    assign bus.locked      = (state == ST_LOCK);
    assign bus.err_multi   = err_multi_q;
    assign bus.err_order   = err_order_q;
    assign bus.err_gap     = err_gap_q;
    assign bus.err_timeout = err_timeout_q;

`ifdef CPU_PHASE_MON_CYCCNT_EN
    logic [15:0] cycle_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= '0;
        end else if (accept && (dec_idx == PH_12)) begin
            cycle_count_q <= cycle_count_q + 16'd1;
        end
    end

    assign bus.cycle_count = cycle_count_q;
`else
    assign bus.cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_phase_monitor.sv
module tb_cpu_phase_monitor;
    import cpu_phase_pkg::*;

    localparam int GAP = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cpu_phase_monitor_if bus ();

    cpu_phase_monitor #(.STROBE_GAP(GAP), .GAP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Observation counters, cleared by each scenario as it needs them.
    int obs_pv, obs_cs, obs_cd, first_pv_cyc;
    int cd_cyc[$];

    // Reference model: phase tracking by absolute clk timestamps.
    logic [14:0] m_sq;
    bit          m_lock;
    int          m_exp, m_last, m_idx, m_cnt;
    bit          m_pv, m_cs, m_cd, m_em, m_eo, m_eg, m_et;

    function automatic logic [14:0] onehot(input int ph);
        logic [14:0] v;
        v = '0;
        v[ph] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_sq = '0; m_lock = 0; m_exp = 0; m_idx = 0; m_last = cyc + 1;
        m_pv = 0; m_cs = 0; m_cd = 0; m_em = 0; m_eo = 0; m_eg = 0; m_et = 0;
        m_cnt = 0;
    endtask

    // Outcome of the registered strobe at the coming edge (time t = cyc+1).
    task automatic model_eval(input logic clr);
        int t, d, n, idx;
        bit acc;
        t = cyc + 1;
        d = t - m_last;
        n = $countones(m_sq);
        idx = 0;
        for (int i = 0; i < 15; i++) if (m_sq[i]) idx = i;
        acc = 0;
        if (clr) begin m_em = 0; m_eo = 0; m_eg = 0; m_et = 0; end
        m_pv = 0; m_cs = 0; m_cd = 0;
        if (!m_lock) begin
            if (n > 1) m_em = 1;
            else if (m_sq == 15'h0001) acc = 1;
        end else if (n > 1) begin
            m_em = 1; m_lock = 0;
        end else if (n == 1) begin
            if (d < GAP)           begin m_eg = 1; m_lock = 0; end
            else if (d > GAP)      begin m_et = 1; m_lock = 0; end
            else if (idx != m_exp) begin m_eo = 1; m_lock = 0; end
            else acc = 1;
        end else if (d > GAP) begin
            m_et = 1; m_lock = 0;
        end
        if (acc) begin
            m_pv = 1; m_idx = idx; m_cs = (idx == 0); m_cd = (idx == 14);
            m_exp = (idx + 1) % 15; m_lock = 1; m_last = t;
`ifdef CPU_PHASE_MON_CYCCNT_EN
            if (idx == 14) m_cnt = (m_cnt + 1) % 65536;
`endif
        end
        if (!m_lock) m_exp = 0;
    endtask

    task automatic compare_model(input string name);
        logic [27:0] act, exp;
        act = {bus.phase_valid, bus.phase_idx, bus.cycle_start, bus.cycle_done,
               bus.locked, bus.err_multi, bus.err_order, bus.err_gap,
               bus.err_timeout, bus.cycle_count};
        exp = {m_pv, 4'(m_idx), m_cs, m_cd, m_lock, m_em, m_eo, m_eg, m_et,
               16'(m_cnt)};
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
        if (bus.phase_valid === 1'b1) begin
            obs_pv++;
            if (first_pv_cyc < 0) first_pv_cyc = cyc;
        end
        if (bus.cycle_start === 1'b1) obs_cs++;
        if (bus.cycle_done === 1'b1) begin obs_cd++; cd_cyc.push_back(cyc); end
    endtask

    task automatic clear_obs();
        obs_pv = 0; obs_cs = 0; obs_cd = 0; first_pv_cyc = -1;
        cd_cyc.delete();
    endtask

    // One clk: drive inputs, advance model, sample 1 time unit after the edge.
    task automatic step(input logic [14:0] s, input logic clr);
        reset         = 1'b0;
        bus.strobe_in = s;
        bus.clear_err = clr;
        model_eval(clr);
        m_sq = s;
        @(posedge clk); #1;
        cyc++;
        compare_model("model");
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            reset         = 1'b1;
            bus.strobe_in = 15'($urandom);
            bus.clear_err = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
            model_reset();
            compare_model("reset_model");
        end
        reset = 1'b0;
    endtask

    task automatic send_phase(input int ph);
        step(onehot(ph), 1'b0);
        step('0, 1'b0);
    endtask

    task automatic test_reset();
        logic [27:0] act;
        reset_cycles(3);
        step('0, 1'b0);
        act = {bus.phase_valid, bus.phase_idx, bus.cycle_start, bus.cycle_done,
               bus.locked, bus.err_multi, bus.err_order, bus.err_gap,
               bus.err_timeout, bus.cycle_count};
        compared++;
        if (act !== 28'h0) begin
            mismatched++;
            $display("FAIL reset_outputs got=%h want=0", act);
        end
    endtask

    task automatic test_legal();
        int drive_cyc;
        reset_cycles(1);
        for (int i = 0; i < 9; i++) step('0, 1'b0);
        clear_obs();
        drive_cyc = cyc;
        for (int p = 0; p < 30; p++) send_phase(p % 15);
        compared++;
        if (obs_pv != 30 || obs_cs != 2 || obs_cd != 2) begin
            mismatched++;
            $display("FAIL legal_pulses got pv=%0d cs=%0d cd=%0d want 30/2/2", obs_pv, obs_cs, obs_cd);
        end
        compared++;
        if (first_pv_cyc - drive_cyc != 2) begin
            mismatched++;
            $display("FAIL legal_latency got=%0d want=2", first_pv_cyc - drive_cyc);
        end
        compared++;
        if (cd_cyc.size() != 2 || cd_cyc[0] - drive_cyc != 30 || cd_cyc[1] - drive_cyc != 60) begin
            mismatched++;
            $display("FAIL legal_done_times got n=%0d want offsets 30,60", cd_cyc.size());
        end
        compared++;
        if ({bus.locked, bus.err_multi, bus.err_order, bus.err_gap, bus.err_timeout} !== 5'b10000) begin
            mismatched++;
            $display("FAIL legal_status got=%b want=10000",
                     {bus.locked, bus.err_multi, bus.err_order, bus.err_gap, bus.err_timeout});
        end
    endtask

    task automatic test_order();
        reset_cycles(1);
        for (int p = 0; p < 4; p++) send_phase(p);
        clear_obs();
        send_phase(5);
        compared++;
        if (bus.err_order !== 1'b1 || bus.locked !== 1'b0 || obs_pv != 0) begin
            mismatched++;
            $display("FAIL order_err got eo=%b lk=%b pv=%0d want 1/0/0", bus.err_order, bus.locked, obs_pv);
        end
        send_phase(0);
        compared++;
        if (bus.locked !== 1'b1 || bus.phase_idx !== 4'd0) begin
            mismatched++;
            $display("FAIL order_relock got lk=%b idx=%0d want 1/0", bus.locked, bus.phase_idx);
        end
    endtask

    task automatic test_multi();
        reset_cycles(1);
        for (int p = 0; p < 3; p++) send_phase(p);
        step(15'h0003, 1'b0);
        step('0, 1'b0);
        compared++;
        if (bus.err_multi !== 1'b1 || bus.locked !== 1'b0) begin
            mismatched++;
            $display("FAIL multi_err got em=%b lk=%b want 1/0", bus.err_multi, bus.locked);
        end
        step('0, 1'b1);
        compared++;
        if (bus.err_multi !== 1'b0) begin
            mismatched++;
            $display("FAIL multi_clear got=%b want=0", bus.err_multi);
        end
    endtask

    task automatic test_timeout_gap();
        reset_cycles(1);
        for (int p = 0; p <= 7; p++) send_phase(p);
        step('0, 1'b0);
        step('0, 1'b0);
        compared++;
        if (bus.err_timeout !== 1'b0 || bus.locked !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_early got et=%b lk=%b want 0/1", bus.err_timeout, bus.locked);
        end
        step('0, 1'b0);
        compared++;
        if (bus.err_timeout !== 1'b1 || bus.locked !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_err got et=%b lk=%b want 1/0", bus.err_timeout, bus.locked);
        end
        step('0, 1'b1);
        clear_obs();
        step(onehot(0), 1'b0);
        step(onehot(1), 1'b0);
        step('0, 1'b0);
        step('0, 1'b0);
        compared++;
        if (bus.err_gap !== 1'b1 || bus.locked !== 1'b0 || obs_pv != 1 || bus.err_timeout !== 1'b0) begin
            mismatched++;
            $display("FAIL gap_err got eg=%b lk=%b pv=%0d et=%b want 1/0/1/0",
                     bus.err_gap, bus.locked, obs_pv, bus.err_timeout);
        end
    endtask

    task automatic test_hunt();
        reset_cycles(1);
        clear_obs();
        for (int i = 0; i < 5; i++) send_phase(2);
        compared++;
        if (obs_pv != 0 || {bus.err_multi, bus.err_order, bus.err_gap, bus.err_timeout} !== 4'b0) begin
            mismatched++;
            $display("FAIL hunt_ignore got pv=%0d errs=%b want 0/0000", obs_pv,
                     {bus.err_multi, bus.err_order, bus.err_gap, bus.err_timeout});
        end
        send_phase(0);
        send_phase(1);
        step(onehot(5), 1'b0);
        step('0, 1'b1);
        compared++;
        if (bus.err_order !== 1'b1) begin
            mismatched++;
            $display("FAIL clear_vs_new got=%b want=1", bus.err_order);
        end
    endtask

    task automatic test_cyccnt();
        int want;
        reset_cycles(1);
        for (int p = 0; p < 45; p++) send_phase(p % 15);
`ifdef CPU_PHASE_MON_CYCCNT_EN
        want = 3;
`else
        want = 0;
`endif
        compared++;
        if (bus.cycle_count !== 16'(want)) begin
            mismatched++;
            $display("FAIL cyccnt_periods got=%0d want=%0d", bus.cycle_count, want);
        end
        for (int p = 0; p < 5; p++) send_phase(p);
        reset_cycles(1);
        compared++;
        if (bus.cycle_count !== 16'd0 || bus.locked !== 1'b0) begin
            mismatched++;
            $display("FAIL cyccnt_reset got cnt=%0d lk=%b want 0/0", bus.cycle_count, bus.locked);
        end
    endtask

    task automatic test_random();
        int gp, r;
        logic clr;
        gp = 0;
        reset_cycles(1);
        for (int i = 0; i < 1500; i++) begin
            r   = $urandom_range(0, 99);
            clr = ($urandom_range(0, 39) == 0);
            if (r < 80) begin
                step(onehot(gp), clr); step('0, 1'b0); gp = (gp + 1) % 15;
            end else if (r < 85) begin
                step(onehot($urandom_range(0, 14)), clr); step('0, 1'b0);
            end else if (r < 89) begin
                step(15'($urandom), clr); step('0, 1'b0);
            end else if (r < 93) begin
                step('0, clr); step('0, 1'b0); gp = (gp + 1) % 15;
            end else if (r < 97) begin
                step(onehot(gp), clr); gp = (gp + 1) % 15;
            end else if (r < 99) begin
                step('0, clr);
            end else begin
                reset_cycles(1);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.strobe_in = '0;
        bus.clear_err = 1'b0;
        clear_obs();
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_legal();
        test_order();
        test_multi();
        test_timeout_gap();
        test_hunt();
        test_cyccnt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cpu_phase_monitor.md
Name: cpu_phase_monitor

Overview:
- Receiver and checker for the 15-strobe CPU phase sequence.
  - The phase generator emits one-cycle pulses clock_1, clock_2, clock_3, clock_4, clock_4_2, clock_5, clock_6, clock_6_2, clock_7, clock_8, clock_8_2, clock_9, clock_10, clock_11, clock_12.
  - Strobes are spaced 2 clk apart; the sequence period is 30 clk.
- Block decodes the strobes into a phase index, locks onto the sequence, and flags protocol violations.
- Sits beside the CPU datapath. Feeds phase index and cycle markers to debug/trace logic and fault reporting.

Parameters:
- NUM_PHASES, 15, number of strobes per CPU cycle.
- STROBE_GAP, 2, required clk distance between consecutive strobes, including clock_12 -> clock_1.
- GAP_W, 4, width of the gap counter; must hold STROBE_GAP+1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- strobe_in  in  15  bit0=clock_1 ... bit14=clock_12, in the order listed in Overview.
- clear_err  in  1  one-cycle pulse that clears sticky error flags.
- phase_valid  out  1  one-cycle pulse: a strobe was accepted.
- phase_idx  out  4  index 0..14 of the last accepted strobe.
- cycle_start  out  1  pulse when clock_1 is accepted.
- cycle_done  out  1  pulse when clock_12 is accepted.
- locked  out  1  high while FSM is in LOCK.
- err_multi  out  1  sticky: more than one strobe bit high in a cycle.
- err_order  out  1  sticky: accepted-position strobe was not the expected phase.
- err_gap  out  1  sticky: strobe arrived earlier than STROBE_GAP.
- err_timeout  out  1  sticky: no strobe within STROBE_GAP.
- cycle_count  out  16  completed CPU cycles (see Optional Feature).

Behaviour:
- Reset values:
  - All outputs 0; phase_idx=0.
  - FSM=HUNT; expected index=0; gap counter=0; input register=0.
- Pipeline:
  - strobe_in is registered once (s_q); all checks use s_q.
  - All outputs are registered, so a strobe at cycle N produces phase_valid at cycle N+2.
- Decode:
  - popcount(s_q)==0: no event.
  - popcount==1: idx = bit position.
  - popcount>1: multi event.
- Gap counter:
  - Cleared to 0 when a strobe is accepted; increments each cycle; saturates at 2^GAP_W-1.
  - A strobe is on time iff it arrives when the counter value +1 == STROBE_GAP.
- FSM HUNT:
  - Only s_q == bit0 is acted on. It goes to LOCK with expected=1 and pulses phase_valid and cycle_start with phase_idx=0.
  - Any other single strobe is ignored, with no error.
  - A multi event sets err_multi and stays in HUNT.
- FSM LOCK, per cycle, evaluated in priority order:
  1. Multi event: set err_multi, go to HUNT.
  2. Single strobe that is early (counter+1 < STROBE_GAP): set err_gap, go to HUNT.
  3. Single strobe on time but idx != expected: set err_order, go to HUNT.
  4. Single strobe on time and idx == expected: accept.
     - Pulse phase_valid; load phase_idx.
     - expected = (idx==14) ? 0 : idx+1.
     - cycle_done when idx==14; cycle_start when idx==0.
  5. No strobe and counter+1 > STROBE_GAP: set err_timeout, go to HUNT.
- Rejected strobes never pulse phase_valid.
- Leaving LOCK:
  - locked drops in the cycle the error flag rises.
  - expected resets to 0 on entering HUNT.
- Sticky errors:
  - Set on their event; cleared only by clear_err or reset.
  - clear_err in the same cycle as a new error: the flag ends up set.
- Reset asserted mid-sequence:
  - Returns to HUNT next clk.
  - Strobes present during reset are discarded.

Optional Feature:
- Macro CPU_PHASE_MON_CYCCNT_EN.
- Defined:
  - cycle_count increments by 1 in the same cycle as each cycle_done; wraps 0xFFFF -> 0x0000.
  - Cleared by reset only; clear_err does not affect it.
- Undefined:
  - cycle_count tied to 0; no counter flops.
  - All other behaviour is identical.

Decomposition:
- Package cpu_phase_pkg:
  - NUM_PHASES.
  - Phase index constants PH_1=0 ... PH_12=14, in the strobe order above.
  - FSM state enum {HUNT, LOCK}.
  - Default STROBE_GAP.
- Sub-module cpu_phase_onehot_dec: combinational 15-bit -> {valid, multi, idx[3:0]}. Reused by trace logic.

Test Plan:
- Reset, then a legal sequence: clock_1 at cycle 10, each next strobe +2, two full periods -> phase_valid at 12, 14, ...; phase_idx 0..14..0; cycle_done at 40 and 70; locked=1 from 12; no errors.
- Legal lock, then clock_5 (bit5) where clock_4_2 (bit4) is expected -> err_order=1, locked=0, no phase_valid for that strobe; next clock_1 relocks.
- Locked, then strobe_in=15'h0003 -> err_multi=1, HUNT; clear_err pulse -> err_multi=0.
- Locked, then clock_7 omitted -> err_timeout at STROBE_GAP+1 after clock_6_2 is sampled; a strobe 1 clk after the previous one -> err_gap.
- HUNT with only clock_3 pulses -> no phase_valid and no errors; clear_err concurrent with a new order error -> err_order stays 1.
- With CPU_PHASE_MON_CYCCNT_EN: 3 full periods -> cycle_count=3; reset mid-period -> cycle_count=0, locked=0. Without the macro: cycle_count stays 0.
